// File: rtl/ic2_arbiter.sv
// Round-robin arbiter that lets two requesters share one IC2 master.
// A grant latches the winner's command into the master-side outputs. START then fires a
// one-cycle strobe. WAIT times the transaction for TXN_CYCLES clocks. DONE acknowledges
// the winner and captures read data if the transaction was a read.
module ic2_arbiter #(
  parameter int unsigned TXN_CYCLES = 116
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        rnw0,
  input  logic        rnw1,
  input  logic [6:0]  addr0,
  input  logic [6:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        start_stb,
  output logic        rnw,
  output logic [6:0]  ic2_addr,
  output logic [15:0] wr_data,
  input  logic [15:0] rd_data,
  output logic        busy,
  output logic        owner
);

  localparam logic [7:0] CntLoad = 8'(TXN_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  state_e     state;
  logic [7:0] cnt;
  // Last-served requester. It resets to 1 so that requester 0 wins the first tie.
  logic       last;
  logic       grant;

  // Winner selection: on a tie the requester that was not served last wins.
  // A lone requester always wins.
  assign grant = (req0 && req1) ? ~last : req1;

  // Transaction FSM. All outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cnt       <= '0;
      last      <= 1'b1;
      owner     <= 1'b0;
      start_stb <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
      rnw       <= 1'b0;
      ic2_addr  <= '0;
      wr_data   <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      start_stb <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req0 || req1) begin
            owner     <= grant;
            rnw       <= grant ? rnw1 : rnw0;
            ic2_addr  <= grant ? addr1 : addr0;
            wr_data   <= grant ? wdata1 : wdata0;
            start_stb <= 1'b1;
            busy      <= 1'b1;
            state     <= StStart;
          end
        end
        StStart: begin
          cnt   <= CntLoad;
          state <= StWait;
        end
        StWait: begin
          if (cnt == 8'd0) begin
            // The acknowledge and the read capture both land in the DONE cycle.
            // RDATAx is therefore already valid while ACKx is high.
            if (owner) begin
              ack1 <= 1'b1;
              if (rnw) rdata1 <= rd_data;
            end else begin
              ack0 <= 1'b1;
              if (rnw) rdata0 <= rd_data;
            end
            last  <= owner;
            state <= StDone;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ic2_arbiter.sv
// Self-checking bench for ic2_arbiter: directed vectors, multi-cycle corner sequences
// and random transactions against a transaction-level round-robin model.
module tb_ic2_arbiter;

  localparam int unsigned TXN = 116;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, rnw0, rnw1;
  logic [6:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1, rd_data;
  logic        ack0, ack1, start_stb, rnw, busy, owner;
  logic [15:0] rdata0, rdata1, wr_data;
  logic [6:0]  ic2_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        r0, r1, rw0, rw1;
    logic [6:0]  a0, a1;
    logic [15:0] d0, d1, rd;
    logic        disturb;
    logic        e_own, e_rnw;
    logic [6:0]  e_addr;
    logic [15:0] e_wdata, e_rd0, e_rd1;
  } vec_t;

  ic2_arbiter #(.TXN_CYCLES(TXN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .rnw0      (rnw0),
    .rnw1      (rnw1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .start_stb (start_stb),
    .rnw       (rnw),
    .ic2_addr  (ic2_addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .busy      (busy),
    .owner     (owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one full transaction starting from an IDLE negedge and ends on the IDLE negedge after it.
  task automatic do_txn(input vec_t v);
    bit found;
    bit got;
    int n;
    int extra;
    req0 = v.r0; req1 = v.r1; rnw0 = v.rw0; rnw1 = v.rw1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1; rd_data = v.rd;
    found = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (start_stb) begin
        found = 1;
        break;
      end
    end
    chk("start_seen", 32'(found), 32'd1);
    if (!found) begin
      req0 = 0; req1 = 0;
      return;
    end
    chk("grant_owner", 32'(owner), 32'(v.e_own));
    chk("grant_rnw", 32'(rnw), 32'(v.e_rnw));
    chk("grant_addr", 32'(ic2_addr), 32'(v.e_addr));
    chk("grant_wdata", 32'(wr_data), 32'(v.e_wdata));
    chk("start_busy", 32'(busy), 32'd1);
    n = 0;
    extra = 0;
    if (v.disturb) begin
      @(negedge clk);
      n = 1;
      if (start_stb) extra++;
      req0 = 0; req1 = 0;
      rnw0 = ~rnw0; rnw1 = ~rnw1;
      addr0 = ~addr0; addr1 = ~addr1;
      wdata0 = ~wdata0; wdata1 = ~wdata1;
    end
    got = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (start_stb) extra++;
      if (ack0 || ack1) begin
        got = 1;
        break;
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", n, TXN + 1);
    chk("ack0", 32'(ack0), 32'(v.e_own == 1'b0));
    chk("ack1", 32'(ack1), 32'(v.e_own == 1'b1));
    chk("done_owner", 32'(owner), 32'(v.e_own));
    chk("done_rnw", 32'(rnw), 32'(v.e_rnw));
    chk("done_addr", 32'(ic2_addr), 32'(v.e_addr));
    chk("done_wdata", 32'(wr_data), 32'(v.e_wdata));
    chk("rdata0", 32'(rdata0), 32'(v.e_rd0));
    chk("rdata1", 32'(rdata1), 32'(v.e_rd1));
    chk("done_busy", 32'(busy), 32'd1);
    chk("extra_start", extra, 0);
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("ack0_pulse", 32'(ack0), 32'd0);
    chk("ack1_pulse", 32'(ack1), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  vec_t tbl[6];
  vec_t v;

  initial begin
    bit found;
    int acks;
    logic m_last;
    logic [15:0] m_rd[2];
    logic [1:0] r;

    rst_n = 1;
    req0 = 0; req1 = 0; rnw0 = 0; rnw1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; rd_data = '0;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'h50, 7'h00, 16'hA5C3, 16'h0000, 16'hFFFF, 1'b0,
               1'b0, 1'b0, 7'h50, 16'hA5C3, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 7'h11, 7'h21, 16'h1111, 16'h2222, 16'hBEEF, 1'b0,
               1'b1, 1'b1, 7'h21, 16'h2222, 16'h0000, 16'hBEEF};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'h11, 7'h22, 16'h3333, 16'h4444, 16'h1234, 1'b0,
               1'b0, 1'b1, 7'h11, 16'h3333, 16'h1234, 16'hBEEF};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'h12, 7'h22, 16'h5555, 16'h6666, 16'h9999, 1'b0,
               1'b1, 1'b0, 7'h22, 16'h6666, 16'h1234, 16'hBEEF};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 7'h13, 7'h7F, 16'h0001, 16'h7777, 16'h0F0F, 1'b0,
               1'b1, 1'b1, 7'h7F, 16'h7777, 16'h1234, 16'h0F0F};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'h3C, 7'h01, 16'h1357, 16'h0000, 16'hAAAA, 1'b1,
               1'b0, 1'b0, 7'h3C, 16'h1357, 16'h1234, 16'h0F0F};

    // Asynchronous reset before any clock edge
    #2 rst_n = 0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start_stb), 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_rnw", 32'(rnw), 32'd0);
    chk("rst_addr", 32'(ic2_addr), 32'd0);
    chk("rst_wdata", 32'(wr_data), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_rdata1", 32'(rdata1), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 6; i++) do_txn(tbl[i]);

    // With no request the master-side outputs hold their last values
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_busy", 32'(busy), 32'd0);
      chk("hold_start", 32'(start_stb), 32'd0);
      chk("hold_addr", 32'(ic2_addr), 32'h3C);
      chk("hold_wdata", 32'(wr_data), 32'h1357);
    end

    // Both requesters held through reset release: grants alternate 0,1,0,1
    @(negedge clk);
    rst_n = 0;
    req0 = 1; req1 = 1; rnw0 = 0; rnw1 = 0;
    addr0 = 7'h05; addr1 = 7'h06; wdata0 = 16'h0A0A; wdata1 = 16'h0B0B;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int t = 0; t < 4; t++) begin
      found = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (start_stb) begin
          found = 1;
          break;
        end
      end
      chk("rr_start_seen", 32'(found), 32'd1);
      chk("rr_owner", 32'(owner), 32'(t % 2));
      chk("rr_addr", 32'(ic2_addr), (t % 2 == 0) ? 32'h05 : 32'h06);
      acks = 0;
      found = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        acks += int'(ack0) + int'(ack1);
        if (ack0 || ack1) begin
          found = 1;
          break;
        end
      end
      chk("rr_ack_count", acks, 1);
      chk("rr_ack_who", 32'(ack1), 32'(t % 2));
      if (t == 3) begin
        req0 = 0; req1 = 0;
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // Reset during WAIT of a write: abandoned, then regranted after release
    req0 = 1; rnw0 = 0; addr0 = 7'h2A; wdata0 = 16'hC0DE;
    found = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (start_stb) begin
        found = 1;
        break;
      end
    end
    chk("mid_start_seen", 32'(found), 32'd1);
    repeat (20) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", 32'(ic2_addr), 32'd0);
    chk("mid_rst_wdata", 32'(wr_data), 32'd0);
    chk("mid_rst_owner", 32'(owner), 32'd0);
    chk("mid_rst_ack0", 32'(ack0), 32'd0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      acks += int'(ack0);
    end
    rst_n = 1;
    found = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acks += int'(ack0);
      if (start_stb) begin
        found = 1;
        break;
      end
    end
    chk("mid_no_ack", acks, 0);
    chk("mid_regrant", 32'(found), 32'd1);
    chk("mid_regrant_addr", 32'(ic2_addr), 32'h2A);
    chk("mid_regrant_wdata", 32'(wr_data), 32'hC0DE);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack0) begin
        found = 1;
        break;
      end
    end
    chk("mid_regrant_ack", 32'(found), 32'd1);
    req0 = 0;
    @(negedge clk);

    // Random transactions against a transaction-level model
    apply_reset();
    m_last = 1'b1;
    m_rd[0] = '0;
    m_rd[1] = '0;
    for (int t = 0; t < 60; t++) begin
      r = 2'($urandom_range(1, 3));
      v.r0 = r[0];
      v.r1 = r[1];
      v.rw0 = 1'($urandom);
      v.rw1 = 1'($urandom);
      v.a0 = 7'($urandom);
      v.a1 = 7'($urandom);
      v.d0 = 16'($urandom);
      v.d1 = 16'($urandom);
      v.rd = 16'($urandom);
      v.disturb = ($urandom_range(0, 3) == 0);
      v.e_own = (v.r0 && v.r1) ? ~m_last : v.r1;
      v.e_rnw = v.e_own ? v.rw1 : v.rw0;
      v.e_addr = v.e_own ? v.a1 : v.a0;
      v.e_wdata = v.e_own ? v.d1 : v.d0;
      if (v.e_rnw) m_rd[v.e_own] = v.rd;
      m_last = v.e_own;
      v.e_rd0 = m_rd[0];
      v.e_rd1 = m_rd[1];
      do_txn(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ic2_arbiter.md
IC2_ARBITER -- requirements
Module: ic2_arbiter

Interface
REQ-001 Parameter TXN_CYCLES, default 116, sets the CLK cycles one IC2 transaction occupies: 29 SCL periods at CLK/4. Legal range 2..255.
REQ-002 CLK  in  1  single clock for all logic, rising edge.
REQ-003 RESET  in  1  asynchronous, active-low reset.
REQ-004 REQ0 / REQ1  in  1  request from requester 0 / 1, level, held until ACKx.
REQ-005 RNW0 / RNW1  in  1  1 = read, 0 = write, per requester.
REQ-006 ADDR0 / ADDR1  in  7  IC2 slave address, per requester.
REQ-007 WDATA0 / WDATA1  in  16  write data, per requester.
REQ-008 ACK0 / ACK1  out  1  one-cycle completion pulse, per requester.
REQ-009 RDATA0 / RDATA1  out  16  last read result, per requester.
REQ-010 START_STB  out  1  one-cycle start strobe to the IC2 master.
REQ-011 RNW  out  1  transaction direction to the master.
REQ-012 IC2_ADDR  out  7  slave address to the master.
REQ-013 WR_DATA  out  16  write data to the master.
REQ-014 RD_DATA  in  16  read data from the master, valid at end of transaction.
REQ-015 BUSY  out  1  high in every state except IDLE.
REQ-016 OWNER  out  1  index of the requester currently or last granted.

Function
REQ-017 FSM SHALL have states IDLE, START, WAIT, DONE. State, counter and all outputs are registered.
REQ-018 In IDLE with no REQ high, the FSM SHALL stay in IDLE and all master-side outputs SHALL hold their values.
REQ-019 In IDLE with REQ0 or REQ1 high, on the next edge the FSM SHALL:
- select the winner;
- latch the winner's RNWx/ADDRx/WDATAx into RNW/IC2_ADDR/WR_DATA;
- set OWNER;
- enter START.
REQ-020 Arbitration SHALL be round-robin using a last-served pointer LAST:
- both requesting: grant the requester other than LAST;
- single requester: grant it regardless of LAST.
REQ-021 START_STB SHALL be 1 exactly in the START cycle and 0 otherwise. START SHALL load the counter with TXN_CYCLES-1 and go to WAIT.
REQ-022 WAIT SHALL decrement the counter each cycle and go to DONE in the cycle after the counter reads 0, so WAIT lasts TXN_CYCLES cycles.
REQ-023 In DONE, for OWNER's requester, the block SHALL:
- pulse ACKx for one cycle;
- capture RD_DATA into RDATAx if RNW = 1, otherwise leave RDATAx unchanged;
- set LAST = OWNER;
- return to IDLE.
REQ-024 Latency: if grant occurs at edge k, START_STB is high in cycle k+1 and ACKx is high in cycle k+TXN_CYCLES+2.
REQ-025 RNW, IC2_ADDR, WR_DATA and OWNER SHALL be stable from the grant through DONE. Requester input changes after the grant SHALL be ignored.
REQ-026 REQx deasserted during START or WAIT SHALL NOT abort the transaction. ACKx SHALL still pulse.
REQ-027 REQx still high in the IDLE cycle after ACKx SHALL be treated as a new request. Round-robin then grants the other requester first if both are high.
REQ-028 Requests arriving outside IDLE SHALL be held pending by the requester and never lost or queued internally.
REQ-029 RDATAx SHALL hold its value until that requester's next read completes.

Reset
REQ-030 RESET low SHALL immediately force the following, regardless of the clock:
- state IDLE, counter 0, LAST = 1, OWNER = 0;
- START_STB, ACK0, ACK1, BUSY, RNW = 0;
- IC2_ADDR, WR_DATA, RDATA0, RDATA1 = 0.
REQ-031 Reset asserted mid-transaction SHALL abandon it with no ACK. After release, the first edge with a REQ high SHALL grant normally, with requester 0 winning a tie.

Verification
REQ-032 REQ0 = 1, RNW0 = 0, ADDR0 = 7'h50, WDATA0 = 16'hA5C3, TXN_CYCLES = 116 -> START_STB pulses once with IC2_ADDR = 50, WR_DATA = A5C3, RNW = 0; ACK0 fires 117 cycles later; RDATA0 remains 0.
REQ-033 REQ1 read of ADDR1 = 7'h21, RD_DATA driven 16'hBEEF during WAIT/DONE -> ACK1 pulses; RDATA1 = BEEF; RDATA0 unchanged.
REQ-034 REQ0 and REQ1 asserted together and held through reset release -> grants alternate 0,1,0,1 over four transactions; OWNER matches; exactly one ACK per transaction.
REQ-035 RESET pulsed low during WAIT of a REQ0 write -> outputs zero asynchronously; no ACK0; after release the held REQ0 is regranted with a fresh START_STB.
REQ-036 ADDR0/WDATA0 changed and REQ0 dropped during WAIT -> master-side outputs unchanged until DONE; ACK0 still pulses; the FSM then stays in IDLE with BUSY = 0.
